// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared instruction-fetch types and constants
//
// Fetch state encoding and word constants shared by fetch, decode and
// hazard logic.
package fetch_unit_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] IF_NOP_INSTR = 16'h0000;
    localparam logic [WORD_W-1:0] IF_PC_STEP   = 16'd2;

    // FETCH: request outstanding (or about to be raised after reset)
    // HOLD : word parked in the hold buffer while decode stalls, no request
    // DROP : redirect waiting for the in-flight request to complete
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Instruction addresses are halfword aligned; bit0 is never stored.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem req/ack fetch, hold buffer, redirect
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   stall                   decode hazard hold; IF/ID must not change
//   branch_taken/addr       redirect request from MEM and its target
//   imem_req/addr           registered request to instruction memory
//   imem_ack/rdata          memory response, valid only while imem_req=1
//   IFID_instr/pc/valid     registered IF/ID pipeline register to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = IF_NOP_INSTR,
    parameter logic [WORD_W-1:0] PC_STEP   = IF_PC_STEP
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] IFID_instr,
    output logic [WORD_W-1:0] IFID_pc,
    output logic              IFID_valid
);

    fetch_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] redirect_q, redirect_d;
    logic [WORD_W-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_W-1:0] hold_pc_q, hold_pc_d;
    logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [WORD_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic              handshake;
    logic [WORD_W-1:0] br_target;
    logic [WORD_W-1:0] seq_addr;

    // Ack only counts while a request is actually outstanding.
    assign handshake = req_q & imem_ack;
    assign br_target = align_pc(branch_addr);
    assign seq_addr  = align_pc(addr_q + PC_STEP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            redirect_q   <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            redirect_q   <= redirect_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // A bubble clears instr/valid but keeps the last pc; it also overrides
    // stall, so flushes land even while decode is holding.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        redirect_d   = redirect_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // Only reachable straight out of reset: nothing in
                    // flight, so a branch can retarget the first request.
                    req_d = 1'b1;
                    if (branch_taken) begin
                        addr_d       = br_target;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end else if (!stall) begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                end else if (handshake) begin
                    if (branch_taken) begin
                        addr_d       = br_target;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end else if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = addr_q;
                        addr_d       = seq_addr;
                        req_d        = 1'b0;
                        state_d      = HOLD;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = addr_q;
                        ifid_valid_d = 1'b1;
                        addr_d       = seq_addr;
                    end
                end else begin
                    if (branch_taken) begin
                        // The open handshake must finish at the old address.
                        redirect_d   = br_target;
                        state_d      = DROP;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end else if (!stall) begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    hold_instr_d = NOP_INSTR;
                    hold_pc_d    = '0;
                    addr_d       = br_target;
                    req_d        = 1'b1;
                    state_d      = FETCH;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    ifid_instr_d = hold_instr_q;
                    ifid_pc_d    = hold_pc_q;
                    ifid_valid_d = 1'b1;
                    hold_instr_d = NOP_INSTR;
                    hold_pc_d    = '0;
                    req_d        = 1'b1;
                    state_d      = FETCH;
                end
            end

            DROP: begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (branch_taken) begin
                    redirect_d = br_target;
                end
                if (handshake) begin
                    addr_d  = branch_taken ? br_target : redirect_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign IFID_instr = ifid_instr_q;
    assign IFID_pc    = ifid_pc_q;
    assign IFID_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_pc;
    logic        IFID_valid;

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000),
        .PC_STEP   (16'd2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .IFID_instr   (IFID_instr),
        .IFID_pc      (IFID_pc),
        .IFID_valid   (IFID_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {pc, instr} expected on IF/ID, in order.
    logic [31:0] sb[$];

    // Reference model of the fetch side.
    logic        m_req;
    logic [15:0] m_addr;
    logic [15:0] m_redir;
    int          m_mode;     // 0 fetch, 1 hold, 2 drop
    int          lat;
    int          wait_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req    = 1'b0;
        m_addr   = 16'h0000;
        m_redir  = 16'h0000;
        m_mode   = 0;
        wait_cnt = 0;
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},   imem_req,   1'b0);
        check_eq({tag, "_addr"},  imem_addr,  16'h0000);
        check_eq({tag, "_instr"}, IFID_instr, 16'h0000);
        check_eq({tag, "_pc"},    IFID_pc,    16'h0000);
        check_eq({tag, "_valid"}, IFID_valid, 1'b0);
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic cycle(input logic st, input logic br, input logic [15:0] ba);
        logic        ack;
        logic        req_now;
        logic [15:0] tgt;
        logic [15:0] rd;
        logic [31:0] e;

        check_eq("imem_req", imem_req, m_req);
        if (m_req) check_eq("imem_addr", imem_addr, m_addr);

        tgt     = {ba[15:1], 1'b0};
        req_now = m_req;
        ack     = m_req && (wait_cnt >= lat);
        rd      = m_addr ^ 16'hA5A5;

        stall        = st;
        branch_taken = br;
        branch_addr  = ba;
        imem_ack     = ack;
        imem_rdata   = ack ? rd : 16'hDEAD;

        case (m_mode)
            0: begin
                if (!m_req) begin
                    if (br) m_addr = tgt;
                    m_req = 1'b1;
                end else if (ack) begin
                    if (br) begin
                        m_addr = tgt;
                    end else if (st) begin
                        sb.push_back({m_addr, rd});
                        m_addr = m_addr + 16'd2;
                        m_req  = 1'b0;
                        m_mode = 1;
                    end else begin
                        sb.push_back({m_addr, rd});
                        m_addr = m_addr + 16'd2;
                    end
                end else if (br) begin
                    m_redir = tgt;
                    m_mode  = 2;
                end
            end
            1: begin
                if (br) begin
                    if (sb.size() > 0) void'(sb.pop_back());
                    m_addr = tgt;
                    m_req  = 1'b1;
                    m_mode = 0;
                end else if (!st) begin
                    m_req  = 1'b1;
                    m_mode = 0;
                end
            end
            default: begin
                if (br) m_redir = tgt;
                if (ack) begin
                    m_addr = m_redir;
                    m_mode = 0;
                end
            end
        endcase

        @(posedge clock);
        @(negedge clock);

        if (req_now && ack) wait_cnt = 0;
        else if (req_now)   wait_cnt++;

        if (br) begin
            check_eq("flush_valid", IFID_valid, 1'b0);
            check_eq("flush_instr", IFID_instr, 16'h0000);
        end else if (!st && IFID_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", IFID_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_eq("ifid_pc",    IFID_pc,    e[31:16]);
                check_eq("ifid_instr", IFID_instr, e[15:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 16'h0000;
        imem_ack     = 1'b0;
        imem_rdata   = 16'h0000;
        model_reset();
        lat = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values("rst");
        reset_n = 1'b1;

        // zero-latency streaming
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);

        // three-cycle ack latency
        lat = 3;
        repeat (10) cycle(1'b0, 1'b0, 16'h0000);

        // stall on an acked word -> HOLD, then release
        lat = 0;
        repeat (4) cycle(1'b1, 1'b0, 16'h0000);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000);

        // branch while a request is waiting on a slow memory -> DROP
        lat = 2;
        cycle(1'b0, 1'b1, 16'h0041);
        repeat (2) cycle(1'b0, 1'b0, 16'h0000);
        check_eq("drop_addr", imem_addr, 16'h0040);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000);

        // DROP with a second branch overriding the redirect target
        cycle(1'b0, 1'b1, 16'h0080);
        cycle(1'b1, 1'b1, 16'h0091);
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);

        // branch + stall while holding a word
        lat = 0;
        cycle(1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 16'h0100);
        check_eq("hold_br_addr", imem_addr, 16'h0100);
        check_eq("hold_br_req",  imem_req,  1'b1);
        repeat (3) cycle(1'b0, 1'b0, 16'h0000);

        // address wrap at the top of memory
        cycle(1'b0, 1'b1, 16'hFFFC);
        repeat (4) cycle(1'b0, 1'b0, 16'h0000);

        // reset in the middle of a waiting request
        lat = 3;
        cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clock);
        @(negedge clock);
        reset_n  = 1'b1;
        imem_ack = 1'b0;
        model_reset();
        lat = 0;
        repeat (4) cycle(1'b0, 1'b0, 16'h0000);

        check_eq("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
